// File: rtl/dvs_pkt_encoder.sv
// DVS address-event to SpiNNaker 40-bit multicast packet encoder with a
// first-word-fall-through packet FIFO and delivered/dropped event counters.
module dvs_pkt_encoder #(
    parameter logic [16:0] KEY_PREFIX     = 17'h00000,
    parameter int          FIFO_DEPTH     = 4,
    parameter bit          DROP_WHEN_FULL = 1'b1
) (
    input  logic        CLK_IN,
    input  logic        RESET_IN,
    input  logic [6:0]  EVT_X_IN,
    input  logic [6:0]  EVT_Y_IN,
    input  logic        EVT_POL_IN,
    input  logic        EVT_VLD_IN,
    output logic        EVT_RDY_OUT,
    output logic [39:0] PKT_DATA_OUT,
    output logic        PKT_VLD_OUT,
    input  logic        PKT_RDY_IN,
    input  logic        CLR_CNT_IN,
    output logic [31:0] PKT_CNT_OUT,
    output logic [15:0] DROP_CNT_OUT
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [39:0]      mem_q [FIFO_DEPTH];
    logic [39:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pkt_cnt_q, pkt_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [31:0] routing_key;
    logic [39:0] pkt_word;
    logic        fifo_full;
    logic        fifo_empty;
    logic        offered;
    logic        push;
    logic        pop;
    logic        drop;

    assign routing_key = {KEY_PREFIX, EVT_Y_IN, EVT_X_IN, EVT_POL_IN};
    // Parity bit makes the whole 40-bit word carry an odd number of ones.
    assign pkt_word    = {routing_key, 7'b0000000, ~^routing_key};

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign offered    = EVT_VLD_IN && !RESET_IN;
    // Fullness is judged on registered state, so a same-edge pop never makes room.
    assign push       = offered && !fifo_full;
    assign drop       = DROP_WHEN_FULL && offered && fifo_full;
    assign pop        = !fifo_empty && PKT_RDY_IN;

    assign EVT_RDY_OUT  = !RESET_IN && (DROP_WHEN_FULL || !fifo_full);
    assign PKT_VLD_OUT  = !fifo_empty;
    assign PKT_DATA_OUT = fifo_empty ? 40'h0 : mem_q[rd_ptr_q];
    assign PKT_CNT_OUT  = pkt_cnt_q;
    assign DROP_CNT_OUT = drop_cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = pkt_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Clear takes priority over any increment on the same edge.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (CLR_CNT_IN) begin
            pkt_cnt_d  = '0;
            drop_cnt_d = '0;
        end else begin
            if (pop) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule
